// File: rtl/hamming_tmr_pkg.sv
// Shared types and Hamming(7,4) helpers for the triplicated writer path.
// Codeword bit i holds Hamming position i+1: {d3,d2,d1,p4,d0,p2,p1}.
package hamming_tmr_pkg;

    typedef logic [6:0] cw_t;

    typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

    // inj_bit value that selects no codeword bit
    localparam logic [2:0] INJ_NONE = 3'd7;

    function automatic cw_t enc74(input logic [3:0] d);
        enc74 = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                 d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    // Syndrome {c4,c2,c1}; a nonzero value names the failing position
    function automatic logic [2:0] syn74(input cw_t cw);
        syn74 = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                 cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                 cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    endfunction

    // Single-error correction; double errors get miscorrected, the voter copes
    function automatic cw_t corr74(input cw_t cw);
        logic [2:0] s;
        cw_t        c;
        s = syn74(cw);
        c = cw;
        if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
        corr74 = c;
    endfunction

    function automatic logic [3:0] ext74(input cw_t cw);
        ext74 = {cw[6], cw[5], cw[4], cw[2]};
    endfunction

endpackage

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) decoder: corrected data, corrected codeword
// (used by the scrubber) and a flag marking a nonzero syndrome.
module hamming74_dec
    import hamming_tmr_pkg::*;
(
    input  cw_t        cw,
    output logic [3:0] data,
    output cw_t        cw_fix,
    output logic       err
);

    assign err    = |syn74(cw);
    assign cw_fix = corr74(cw);
    assign data   = ext74(cw_fix);

endmodule

// File: rtl/tmr_hamming_writer.sv
// Write side of the triplicated Hamming voter path: encodes accepted writes
// into three replica codewords, scrubs one replica per cycle on a periodic
// pass, and applies per-replica fault injection on top of any update.
module tmr_hamming_writer
    import hamming_tmr_pkg::*;
#(
    parameter int SCRUB_PERIOD = 64,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [3:0]       wr_data,
    output logic             wr_ready,
    input  logic [2:0]       inj_en,
    input  logic [2:0]       inj_bit,
    output logic [3:0]       data_1,
    output logic [3:0]       data_2,
    output logic [3:0]       data_3,
    output logic [6:0]       cw_1,
    output logic [6:0]       cw_2,
    output logic [6:0]       cw_3,
    output logic [CNT_W-1:0] corr_cnt,
    output logic             scrub_done
);

    localparam int SC_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  scrub_cnt_q, scrub_cnt_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic             scrub_done_q, scrub_done_d;
    cw_t              cw_q [3];
    cw_t              cw_d [3];

    logic [3:0]       dec_data [3];
    cw_t              dec_fix  [3];
    logic [2:0]       dec_err;

    logic             scrub_due;
    logic             wr_fire;

    // One decoder per replica feeds both the voter outputs and the scrubber
    for (genvar r = 0; r < 3; r++) begin : g_dec
        hamming74_dec u_dec (
            .cw     (cw_q[r]),
            .data   (dec_data[r]),
            .cw_fix (dec_fix[r]),
            .err    (dec_err[r])
        );
    end

    assign scrub_due = (state_q == IDLE) && (scrub_cnt_q == SC_W'(SCRUB_PERIOD - 1));
    assign wr_ready  = (state_q == IDLE) && !scrub_due;
    assign wr_fire   = wr_valid && wr_ready;

    // Next-state: sequencing, write/scrub update, then injection on top
    always_comb begin
        state_d      = state_q;
        scrub_cnt_d  = scrub_cnt_q;
        corr_cnt_d   = corr_cnt_q;
        scrub_done_d = (state_q == S3);
        for (int r = 0; r < 3; r++) cw_d[r] = cw_q[r];

        unique case (state_q)
            IDLE: begin
                if (scrub_due) begin
                    state_d     = S1;
                    scrub_cnt_d = '0;
                end else begin
                    scrub_cnt_d = scrub_cnt_q + 1'b1;
                end
            end
            S1:      state_d = S2;
            S2:      state_d = S3;
            default: state_d = IDLE;
        endcase

        for (int r = 0; r < 3; r++) begin
            if (wr_fire) begin
                cw_d[r] = enc74(wr_data);
            end else if (state_q == state_t'(r + 1) && dec_err[r]) begin
                cw_d[r] = dec_fix[r];
                if (corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (inj_en[r] && inj_bit != INJ_NONE)
                cw_d[r] = cw_d[r] ^ (cw_t'(1) << inj_bit);
        end
    end

    // State, replicas and counters; reset returns to enc(0) everywhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            scrub_cnt_q  <= '0;
            corr_cnt_q   <= '0;
            scrub_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) cw_q[r] <= '0;
        end else begin
            state_q      <= state_d;
            scrub_cnt_q  <= scrub_cnt_d;
            corr_cnt_q   <= corr_cnt_d;
            scrub_done_q <= scrub_done_d;
            for (int r = 0; r < 3; r++) cw_q[r] <= cw_d[r];
        end
    end

    assign cw_1       = cw_q[0];
    assign cw_2       = cw_q[1];
    assign cw_3       = cw_q[2];
    assign data_1     = dec_data[0];
    assign data_2     = dec_data[1];
    assign data_3     = dec_data[2];
    assign corr_cnt   = corr_cnt_q;
    assign scrub_done = scrub_done_q;

endmodule

// File: tb/tb_tmr_hamming_writer.sv
// Scoreboard bench for tmr_hamming_writer: the driver advances a positional
// Hamming reference model each cycle and queues the expected outputs; a
// separate monitor pops and compares them on the falling edge.
module tb_tmr_hamming_writer;

    localparam int P = 8;
    localparam int W = 2;
    localparam int CMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_valid = 1'b0;
    logic [3:0]     wr_data = '0;
    logic           wr_ready;
    logic [2:0]     inj_en = '0;
    logic [2:0]     inj_bit = 3'd7;
    logic [3:0]     data_1, data_2, data_3;
    logic [6:0]     cw_1, cw_2, cw_3;
    logic [W-1:0]   corr_cnt;
    logic           scrub_done;

    tmr_hamming_writer #(.SCRUB_PERIOD(P), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .inj_en(inj_en), .inj_bit(inj_bit),
        .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .cw_1(cw_1), .cw_2(cw_2), .cw_3(cw_3),
        .corr_cnt(corr_cnt), .scrub_done(scrub_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] cw   [3];
        logic [3:0] data [3];
        int         corr;
        bit         done;
        bit         ready;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (phase 0 = idle, 1..3 = scrubbing replica phase)
    logic [6:0] m_cw [3];
    int         m_ph = 0, m_cnt = 0, m_corr = 0;
    bit         m_done = 0;

    // Hamming positions 3,5,6,7 carry d0..d3; the XOR of the positions of all
    // set bits is the syndrome, and parity bits are chosen to make it zero
    function automatic int syn(input logic [6:0] c);
        int s = 0;
        for (int p = 1; p <= 7; p++) if (c[p-1]) s = s ^ p;
        return s;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c = '0;
        int s;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        s = syn(c);
        c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
        return c;
    endfunction

    function automatic logic [6:0] fix(input logic [6:0] c);
        logic [6:0] f = c;
        int s = syn(c);
        if (s != 0) f[s-1] = ~f[s-1];
        return f;
    endfunction

    function automatic logic [3:0] dec(input logic [6:0] c);
        logic [6:0] f = fix(c);
        return {f[6], f[5], f[4], f[2]};
    endfunction

    function automatic bit m_ready();
        return (m_ph == 0) && (m_cnt != P - 1);
    endfunction

    // One clock: drive inputs, predict, then queue the post-edge expectation
    task automatic cycle(input bit r, input bit v, input logic [3:0] d,
                         input logic [2:0] en, input logic [2:0] b);
        logic [6:0] ncw [3];
        int nph, ncnt, ncorr;
        bit ndone, due, hs;
        exp_t e;
        @(negedge clk); #2;
        rst = r; wr_valid = v; wr_data = d; inj_en = en; inj_bit = b;
        if (r) begin
            for (int i = 0; i < 3; i++) ncw[i] = '0;
            nph = 0; ncnt = 0; ncorr = 0; ndone = 0;
        end else begin
            due   = (m_ph == 0) && (m_cnt == P - 1);
            hs    = v && m_ready();
            ncorr = m_corr;
            ndone = (m_ph == 3);
            for (int i = 0; i < 3; i++) begin
                if (hs) ncw[i] = enc(d);
                else if (m_ph == i + 1 && syn(m_cw[i]) != 0) begin
                    ncw[i] = fix(m_cw[i]);
                    if (ncorr < CMAX) ncorr++;
                end else ncw[i] = m_cw[i];
                if (en[i] && b != 3'd7) ncw[i][b] = ~ncw[i][b];
            end
            if (m_ph == 0) begin
                nph  = due ? 1 : 0;
                ncnt = due ? 0 : m_cnt + 1;
            end else begin
                nph  = (m_ph == 3) ? 0 : m_ph + 1;
                ncnt = m_cnt;
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) m_cw[i] = ncw[i];
        m_ph = nph; m_cnt = ncnt; m_corr = ncorr; m_done = ndone;
        for (int i = 0; i < 3; i++) begin
            e.cw[i]   = m_cw[i];
            e.data[i] = dec(m_cw[i]);
        end
        e.corr = m_corr; e.done = m_done; e.ready = m_ready();
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against each queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cw_1", int'(cw_1), int'(e.cw[0]));
                chk("cw_2", int'(cw_2), int'(e.cw[1]));
                chk("cw_3", int'(cw_3), int'(e.cw[2]));
                chk("data_1", int'(data_1), int'(e.data[0]));
                chk("data_2", int'(data_2), int'(e.data[1]));
                chk("data_3", int'(data_3), int'(e.data[2]));
                chk("corr_cnt", int'(corr_cnt), e.corr);
                chk("scrub_done", int'(scrub_done), int'(e.done));
                chk("wr_ready", int'(wr_ready), int'(e.ready));
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 3; i++) m_cw[i] = '0;
        repeat (3) cycle(1, 0, 4'h0, 3'b000, 3'd7);
        cycle(0, 1, 4'b1010, 3'b000, 3'd7);              // cw -> 7'h52
        cycle(0, 1, 4'b1101, 3'b000, 3'd7);              // cw -> 7'h66
        cycle(0, 0, 4'h0, 3'b010, 3'd2);                 // cw_2 -> 7'h62
        repeat (2 * P) cycle(0, 0, 4'h0, 3'b000, 3'd7);  // scrub repairs cw_2
        repeat (P + 6) cycle(0, 1, 4'b0111, 3'b000, 3'd7); // held across due

        // Reset while scrubbing S2 with an upset pending in replica 3
        cycle(0, 0, 4'h0, 3'b100, 3'd5);
        guard = 0;
        while (m_ph != 2 && guard < 4 * P) begin
            cycle(0, 0, 4'h0, 3'b000, 3'd7);
            guard++;
        end
        cycle(1, 0, 4'h0, 3'b000, 3'd7);
        cycle(1, 0, 4'h0, 3'b000, 3'd7);

        // Five single upsets, one per scrub pass: counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            guard = 0;
            while (m_ph != 0 && guard < 8) begin
                cycle(0, 0, 4'h0, 3'b000, 3'd7);
                guard++;
            end
            cycle(0, 0, 4'h0, 3'(1 << $urandom_range(0, 2)), 3'($urandom_range(0, 6)));
            guard = 0;
            do begin
                cycle(0, 0, 4'h0, 3'b000, 3'd7);
                guard++;
            end while (!m_done && guard < 4 * P);
        end

        // Injection coincident with a write: 7'h52 ^ bit6 = 7'h12
        guard = 0;
        while (!m_ready() && guard < 8) begin
            cycle(0, 0, 4'h0, 3'b000, 3'd7);
            guard++;
        end
        cycle(0, 1, 4'b1010, 3'b111, 3'd6);
        cycle(0, 0, 4'h0, 3'b000, 3'd7);

        // Random traffic, sparse injections (double errors included)
        repeat (400) begin
            cycle(0, $urandom_range(0, 1) == 1, 4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000,
                  3'($urandom_range(0, 7)));
        end
        repeat (2) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
